// File: rtl/pool_pkg.sv
// Shared constants and state encoding for the 3x3 max-pool sequencing controller.
package pool_pkg;

    localparam int WIN        = 3;
    localparam int WIN_PIX    = WIN * WIN;
    localparam int PIX_W      = 8;
    localparam int DEF_STRIDE = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pool_ctrl_if.sv
// Memory read, window, pooling-result and write-back signals between pool_ctrl and its neighbours.
interface pool_ctrl_if #(
    parameter int ADDR_W = 12
);
    import pool_pkg::*;

    logic                        mem_rd_en;
    logic [ADDR_W-1:0]           mem_rd_addr;
    logic signed [PIX_W-1:0]     mem_rd_data;
    logic                        win_valid;
    logic [WIN_PIX*PIX_W-1:0]    win_data;
    logic                        pool_valid;
    logic signed [PIX_W-1:0]     pool_max;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic signed [PIX_W-1:0]     wr_data;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output win_valid, win_data,
        input  pool_valid, pool_max,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  win_valid, win_data,
        output pool_valid, pool_max,
        input  wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/pool_addr_gen.sv
// Window walker for pool_ctrl: latched geometry, window origin / in-window counters, read and write addresses.
// Optional POOL_CTRL_STRIDE_EN adds a run-time stride (0 treated as 1); otherwise stride is DEF_STRIDE.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [ADDR_W-1:0] cfg_src_base,
    input  logic [ADDR_W-1:0] cfg_dst_base,
`ifdef POOL_CTRL_STRIDE_EN
    input  logic [1:0]        cfg_stride,
`endif
    input  logic              step_rc,
    input  logic              step_win,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_win
);

    localparam int CW = DIM_W + 2;

    logic [DIM_W-1:0]  w_q, h_q;
    logic [ADDR_W-1:0] src_q, dst_q, out_idx;
    logic [CW-1:0]     col0, row0;
    logic [1:0]        r, c;
    logic [1:0]        stride;
    logic              last_col, last_row;
    logic [ADDR_W-1:0] row_a, col_a, w_a;

`ifdef POOL_CTRL_STRIDE_EN
    logic [1:0] stride_q;

    always_ff @(posedge clk) begin
        if (rst)
            stride_q <= 2'(DEF_STRIDE);
        else if (load)
            stride_q <= (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
    end

    assign stride = stride_q;
`else
    assign stride = 2'(DEF_STRIDE);
`endif

    // A window is last in its row/column when the next origin would leave no room for 3 pixels.
    assign last_col = (col0 + CW'(stride) + CW'(WIN)) > CW'(w_q);
    assign last_row = (row0 + CW'(stride) + CW'(WIN)) > CW'(h_q);
    assign last_win = last_col && last_row;

    assign row_a   = ADDR_W'(row0 + CW'(r));
    assign col_a   = ADDR_W'(col0 + CW'(c));
    assign w_a     = ADDR_W'(w_q);
    assign rd_addr = src_q + row_a * w_a + col_a;
    // Raster order makes oy*OW+ox equal to the number of windows already written.
    assign wr_addr = dst_q + out_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q     <= '0;
            h_q     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            out_idx <= '0;
            col0    <= '0;
            row0    <= '0;
            r       <= '0;
            c       <= '0;
        end else if (load) begin
            w_q     <= cfg_width;
            h_q     <= cfg_height;
            src_q   <= cfg_src_base;
            dst_q   <= cfg_dst_base;
            out_idx <= '0;
            col0    <= '0;
            row0    <= '0;
            r       <= '0;
            c       <= '0;
        end else begin
            if (step_rc) begin
                if (c == 2'(WIN - 1)) begin
                    c <= '0;
                    r <= r + 2'd1;
                end else begin
                    c <= c + 2'd1;
                end
            end
            if (step_win) begin
                r       <= '0;
                c       <= '0;
                out_idx <= out_idx + 1'b1;
                if (last_col) begin
                    col0 <= '0;
                    row0 <= row0 + CW'(stride);
                end else begin
                    col0 <= col0 + CW'(stride);
                end
            end
        end
    end

endmodule

// File: rtl/pool_ctrl.sv
// 3x3 max-pool pass sequencer: fetches each window, hands it to the pooling datapath, writes the result.
// Optional POOL_CTRL_STRIDE_EN adds the cfg_stride port; default build uses a fixed stride of 2.
//
// state | meaning
// IDLE  | waiting for start, cfg sampled here
// FETCH | 9 window reads issued, data shifted into win_data one cycle later
// ISSUE | win_valid pulse to pooling datapath
// WAIT  | win_data held until pool_valid
// WRITE | one-cycle write of pooled result
// DONE  | one-cycle done pulse, then IDLE
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [ADDR_W-1:0] cfg_src_base,
    input  logic [ADDR_W-1:0] cfg_dst_base,
`ifdef POOL_CTRL_STRIDE_EN
    input  logic [1:0]        cfg_stride,
`endif
    output logic              busy,
    output logic              done,
    pool_ctrl_if.master       bus
);

    state_t            state;
    logic [3:0]        issue_cnt;
    logic [3:0]        cap_cnt;
    logic              rd_pend;
    logic              load, step_rc, step_win;
    logic              cfg_empty;
    logic              last_win;
    logic [ADDR_W-1:0] ag_rd_addr, ag_wr_addr;

    assign cfg_empty = (cfg_width < DIM_W'(WIN)) || (cfg_height < DIM_W'(WIN));
    assign load      = (state == ST_IDLE) && start;
    assign step_rc   = (state == ST_FETCH) && (issue_cnt != 4'(WIN_PIX));
    assign step_win  = (state == ST_WRITE) && !last_win;

    pool_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
`ifdef POOL_CTRL_STRIDE_EN
        .cfg_stride   (cfg_stride),
`endif
        .step_rc      (step_rc),
        .step_win     (step_win),
        .rd_addr      (ag_rd_addr),
        .wr_addr      (ag_wr_addr),
        .last_win     (last_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.win_valid   <= 1'b0;
            bus.win_data    <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            issue_cnt       <= '0;
            cap_cnt         <= '0;
            rd_pend         <= 1'b0;
        end else begin
            // Read data arrives the cycle after the request, so capture trails issue by one.
            rd_pend <= bus.mem_rd_en;
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (cfg_empty) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_FETCH;
                            issue_cnt <= '0;
                            cap_cnt   <= '0;
                        end
                    end
                end
                ST_FETCH: begin
                    if (step_rc) begin
                        bus.mem_rd_en   <= 1'b1;
                        bus.mem_rd_addr <= ag_rd_addr;
                        issue_cnt       <= issue_cnt + 4'd1;
                    end else begin
                        bus.mem_rd_en <= 1'b0;
                    end
                    if (rd_pend) begin
                        bus.win_data <= {bus.mem_rd_data, bus.win_data[WIN_PIX*PIX_W-1:PIX_W]};
                        cap_cnt      <= cap_cnt + 4'd1;
                        if (cap_cnt == 4'(WIN_PIX - 1)) begin
                            state         <= ST_ISSUE;
                            bus.win_valid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    bus.win_valid <= 1'b0;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.pool_valid) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_data <= bus.pool_max;
                        bus.wr_addr <= ag_wr_addr;
                        state       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    bus.wr_en <= 1'b0;
                    if (last_win) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= ST_FETCH;
                        issue_cnt <= '0;
                        cap_cnt   <= '0;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
